// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the MIPS pipeline. Owns the program counter,
// issues instruction-memory reads and hands {pc, pc+4, instruction} to
// decode through a registered IF/ID slot. A one-entry skid buffer absorbs
// a memory response that arrives while decode is stalled. Redirects from
// later stages (taken branches/jumps) flush the slot and the skid.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   imem_req     out  read request to instruction memory (REQ/DROP only)
//   imem_addr    out  word-aligned read address, stable while imem_req=1
//   imem_ack     in   memory returns data this cycle (used only with req)
//   imem_rdata   in   instruction word, valid with imem_ack
//   redirect     in   taken branch or jump, sampled every cycle
//   redirect_pc  in   redirect target; bits [1:0] are forced to zero
//   id_stall     in   decode cannot accept a new slot this cycle
//   if_valid     out  IF/ID slot holds a live instruction
//   if_pc        out  address of the slot instruction
//   if_pc_plus4  out  if_pc + 4 (wraps modulo 2^32)
//   if_instr     out  slot instruction word
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PEND = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic [31:0] tgt;
  logic [31:0] tgt_nx;

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        slot_free;
  logic        load_slot;
  logic        load_skid;
  logic        move_skid;
  logic [31:0] redirect_al;
  logic [31:0] pc_plus4;

  assign slot_free   = !if_valid || !id_stall;
  assign redirect_al = redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;

  // Request is a pure decode of the state: in DROP the old address stays on
  // the bus until the outstanding ack arrives, whose data is then thrown away.
  assign imem_req    = (state == REQ) || (state == DROP);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: every clocked register uses non-blocking (<=) assignments so that all
  // flops sample pre-edge values; blocking (=) here would create order-dependent
  // races between always_ff blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and control decode. A redirect overrides both id_stall and the
  // normal fetch flow at the same edge.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block receives a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    state_nx  = state;
    pc_nx     = pc;
    tgt_nx    = tgt;
    load_slot = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;

    unique case (state)
      IDLE: begin
        if (redirect) begin
          pc_nx    = redirect_al;
          state_nx = REQ;
        end else if (slot_free) begin
          state_nx = REQ;
        end
      end

      REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            // Returned word belongs to the wrong path: drop it, refetch now.
            pc_nx = redirect_al;
          end else begin
            // Request must complete at the old address before retargeting.
            tgt_nx   = redirect_al;
            state_nx = DROP;
          end
        end else if (imem_ack) begin
          pc_nx = pc_plus4;
          if (slot_free) begin
            load_slot = 1'b1;
          end else begin
            load_skid = 1'b1;
            state_nx  = PEND;
          end
        end
      end

      PEND: begin
        if (redirect) begin
          pc_nx    = redirect_al;
          state_nx = REQ;
        end else if (!id_stall && skid_valid) begin
          move_skid = 1'b1;
          state_nx  = REQ;
        end
      end

      DROP: begin
        if (redirect) begin
          // The most recent redirect always wins.
          tgt_nx = redirect_al;
          if (imem_ack) begin
            pc_nx    = redirect_al;
            state_nx = REQ;
          end
        end else if (imem_ack) begin
          pc_nx    = tgt;
          state_nx = REQ;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // PC and pending-redirect target
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RESET_PC;
      tgt <= 32'h0;
    end else begin
      pc  <= pc_nx;
      tgt <= tgt_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Skid buffer: holds one response that arrived while decode was stalled.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
    end else if (redirect || move_skid) begin
      skid_valid <= 1'b0;
    end else if (load_skid) begin
      skid_valid <= 1'b1;
      skid_instr <= imem_rdata;
      skid_pc    <= pc;
    end
  end

  // -------------------------------------------------------------------------
  // IF/ID slot. Decode consumes the slot on any edge with if_valid=1 and
  // id_stall=0; if nothing new loads on that edge the slot empties.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid    <= 1'b0;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      if_instr    <= 32'h0;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (load_slot) begin
      if_valid    <= 1'b1;
      if_pc       <= pc;
      if_pc_plus4 <= pc_plus4;
      if_instr    <= imem_rdata;
    end else if (move_skid) begin
      if_valid    <= 1'b1;
      if_pc       <= skid_pc;
      if_pc_plus4 <= skid_pc + 32'd4;
      if_instr    <= skid_instr;
    end else if (if_valid && !id_stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed self-checking bench for if_fetch_stage. The instruction memory is
// a combinational function of imem_addr; the bench controls when it acks.
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Memory contents: a fixed, address-dependent, nonzero pattern.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h2400_5A00;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_stall    (id_stall),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .if_instr    (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and take the IDLE->REQ edge. Leaves pc=0 in REQ.
  task automatic do_reset();
    rst         = 1'b1;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_stall    = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_stall    = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instr} !== {1'b0, 32'h0, 1'b0, 96'h0})
      $display("FAIL reset_outputs: got req=%b addr=%h v=%b pc=%h pc4=%h instr=%h, want all 0",
               imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instr);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0})
      $display("FAIL reset_first_req: got req=%b addr=%h, want req=1 addr=00000000", imem_req, imem_addr);
    else pass_cnt++;
  endtask

  // Reset asserted while a request is live aborts it; a late ack is ignored.
  task automatic test_reset_abort();
    do_reset();
    imem_ack = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (imem_req !== 1'b0)
      $display("FAIL reset_abort_req: got req=%b, want 0", imem_req);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({if_valid, imem_addr} !== {1'b0, 32'h0})
      $display("FAIL reset_abort_slot: got v=%b addr=%h, want v=0 addr=00000000", if_valid, imem_addr);
    else pass_cnt++;
    imem_ack = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] epc;
    do_reset();
    imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      epc = 32'(k * 4);
      step();
      total_cnt++;
      if ({if_valid, if_pc, if_pc_plus4, if_instr, imem_addr} !==
          {1'b1, epc, epc + 32'd4, instr_of(epc), epc + 32'd4})
        $display("FAIL zero_wait_%0d: got v=%b pc=%h pc4=%h instr=%h addr=%h, want v=1 pc=%h pc4=%h instr=%h addr=%h",
                 k, if_valid, if_pc, if_pc_plus4, if_instr, imem_addr,
                 epc, epc + 32'd4, instr_of(epc), epc + 32'd4);
      else pass_cnt++;
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_wait_ack();
    logic [31:0] epc;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      epc = 32'(k * 4);
      for (int w = 0; w < 3; w++) begin
        imem_ack = 1'b0;
        step();
        total_cnt++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, epc, 1'b0})
          $display("FAIL wait_hold_%0d_%0d: got req=%b addr=%h v=%b, want req=1 addr=%h v=0",
                   k, w, imem_req, imem_addr, if_valid, epc);
        else pass_cnt++;
      end
      imem_ack = 1'b1;
      step();
      total_cnt++;
      if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, epc, instr_of(epc), epc + 32'd4})
        $display("FAIL wait_ack_%0d: got v=%b pc=%h instr=%h addr=%h, want v=1 pc=%h instr=%h addr=%h",
                 k, if_valid, if_pc, if_instr, imem_addr, epc, instr_of(epc), epc + 32'd4);
      else pass_cnt++;
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall_skid();
    do_reset();
    imem_ack = 1'b1;
    step();                       // slot <- pc 0
    id_stall = 1'b1;
    step();                       // ack at 4 lands in skid, PEND
    imem_ack = 1'b0;
    total_cnt++;
    if ({imem_req, imem_addr, if_valid, if_pc} !== {1'b0, 32'h8, 1'b1, 32'h0})
      $display("FAIL stall_enter_pend: got req=%b addr=%h v=%b pc=%h, want req=0 addr=00000008 v=1 pc=00000000",
               imem_req, imem_addr, if_valid, if_pc);
    else pass_cnt++;
    repeat (3) step();
    total_cnt++;
    if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 32'h0, instr_of(32'h0)})
      $display("FAIL stall_hold: got req=%b v=%b pc=%h instr=%h, want req=0 v=1 pc=00000000 instr=%h",
               imem_req, if_valid, if_pc, if_instr, instr_of(32'h0));
    else pass_cnt++;
    id_stall = 1'b0;
    step();
    total_cnt++;
    if ({if_valid, if_pc, if_pc_plus4, if_instr, imem_req, imem_addr} !==
        {1'b1, 32'h4, 32'h8, instr_of(32'h4), 1'b1, 32'h8})
      $display("FAIL stall_skid_out: got v=%b pc=%h pc4=%h instr=%h req=%b addr=%h, want v=1 pc=00000004 pc4=00000008 instr=%h req=1 addr=00000008",
               if_valid, if_pc, if_pc_plus4, if_instr, imem_req, imem_addr, instr_of(32'h4));
    else pass_cnt++;
    imem_ack = 1'b1;
    step();
    total_cnt++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h8, instr_of(32'h8)})
      $display("FAIL stall_resume: got v=%b pc=%h instr=%h, want v=1 pc=00000008 instr=%h",
               if_valid, if_pc, if_instr, instr_of(32'h8));
    else pass_cnt++;
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect_drop();
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();                       // REQ, no ack -> DROP
    redirect = 1'b0;
    total_cnt++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL drop_enter: got req=%b addr=%h v=%b, want req=1 addr=00000000 v=0",
               imem_req, imem_addr, if_valid);
    else pass_cnt++;
    step();                       // still waiting in DROP
    imem_ack = 1'b1;
    step();                       // stale data discarded, pc <- tgt
    imem_ack = 1'b0;
    total_cnt++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL drop_retarget: got req=%b addr=%h v=%b, want req=1 addr=00000100 v=0",
               imem_req, imem_addr, if_valid);
    else pass_cnt++;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    total_cnt++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, instr_of(32'h100)})
      $display("FAIL drop_first_fetch: got v=%b pc=%h instr=%h, want v=1 pc=00000100 instr=%h",
               if_valid, if_pc, if_instr, instr_of(32'h100));
    else pass_cnt++;
  endtask

  // Second redirect while in DROP: newest target is used.
  task automatic test_drop_latest();
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();                       // -> DROP, tgt=200
    redirect_pc = 32'h0000_0302;
    step();                       // tgt=300, stay DROP
    redirect = 1'b0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    total_cnt++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h300, 1'b0})
      $display("FAIL drop_latest: got req=%b addr=%h v=%b, want req=1 addr=00000300 v=0",
               imem_req, imem_addr, if_valid);
    else pass_cnt++;
  endtask

  // Redirect with id_stall on the same edge: redirect wins, slot flushed.
  task automatic test_redirect_stall();
    do_reset();
    imem_ack = 1'b1;
    step();                       // slot <- pc 0
    id_stall    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    total_cnt++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40})
      $display("FAIL redirect_stall_flush: got v=%b req=%b addr=%h, want v=0 req=1 addr=00000040",
               if_valid, imem_req, imem_addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({if_valid, if_pc} !== {1'b1, 32'h40})
      $display("FAIL redirect_stall_fetch: got v=%b pc=%h, want v=1 pc=00000040", if_valid, if_pc);
    else pass_cnt++;
    imem_ack = 1'b0;
    id_stall = 1'b0;
  endtask

  // Redirect while in PEND: skid is discarded, never reaches the slot.
  task automatic test_redirect_pend();
    do_reset();
    imem_ack = 1'b1;
    step();
    id_stall = 1'b1;
    step();                       // PEND with skid(pc 4)
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0080;
    step();
    redirect = 1'b0;
    id_stall = 1'b0;
    total_cnt++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h80})
      $display("FAIL redirect_pend: got v=%b req=%b addr=%h, want v=0 req=1 addr=00000080",
               if_valid, imem_req, imem_addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (if_valid !== 1'b0)
      $display("FAIL redirect_pend_skid: got v=%b, want 0", if_valid);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ack    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();                       // ack discarded, pc <- FFFF_FFFC
    redirect = 1'b0;
    total_cnt++;
    if ({if_valid, imem_addr} !== {1'b0, 32'hFFFF_FFFC})
      $display("FAIL wrap_redirect: got v=%b addr=%h, want v=0 addr=fffffffc", if_valid, imem_addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({if_valid, if_pc, if_pc_plus4, if_instr, imem_addr} !==
        {1'b1, 32'hFFFF_FFFC, 32'h0, instr_of(32'hFFFF_FFFC), 32'h0})
      $display("FAIL wrap_slot: got v=%b pc=%h pc4=%h instr=%h addr=%h, want v=1 pc=fffffffc pc4=00000000 instr=%h addr=00000000",
               if_valid, if_pc, if_pc_plus4, if_instr, imem_addr, instr_of(32'hFFFF_FFFC));
    else pass_cnt++;
    step();
    total_cnt++;
    if ({if_valid, if_pc, if_pc_plus4} !== {1'b1, 32'h0, 32'h4})
      $display("FAIL wrap_next: got v=%b pc=%h pc4=%h, want v=1 pc=00000000 pc4=00000004",
               if_valid, if_pc, if_pc_plus4);
    else pass_cnt++;
    imem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_zero_wait();
    test_wait_ack();
    test_stall_skid();
    test_redirect_drop();
    test_drop_latest();
    test_redirect_stall();
    test_redirect_pend();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
